// File: rtl/reg_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_loader_pkg
//  Description : Shared constants, FSM state encoding and count helper for
//                reg_loader and its byte_packer.
//  Optional    : REG_LOADER_READBACK_EN (adds the VERIFY state in reg_loader)
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_loader_pkg;

  localparam int WORD_BYTES = 8;
  localparam int REG_COUNT  = 32;
  localparam int ADDR_W     = 5;
  localparam int CNT_W      = 6;

  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(REG_COUNT);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_COLLECT = 3'd1;
  localparam state_t ST_WRITE   = 3'd2;
  localparam state_t ST_VERIFY  = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  // A count starts real work only in 1..REG_COUNT.
  function automatic logic count_legal(input logic [CNT_W-1:0] c);
    return (c != '0) && (c <= MAX_COUNT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Assembles eight streamed bytes into a 64-bit word using a
//                shift register and a 3-bit byte counter.
//  Ports       : clk, rst_n        clock / async active-low reset
//                i_clear           drop any partial word, restart at byte 0
//                i_shift           accept i_byte this cycle
//                i_lsb_first       1: first byte ends in [7:0], 0: in [63:56]
//                i_byte            payload byte
//                o_word            assembled word (registered)
//                o_last            next accepted byte completes the word
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
  import reg_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic        i_lsb_first,
  input  logic [7:0]  i_byte,
  output logic [63:0] o_word,
  output logic        o_last
);

  logic [63:0] r_word;
  logic [2:0]  r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      // After eight shifts every bit has been replaced, so no clear is
      // needed between consecutive words.
      r_word <= i_lsb_first ? {i_byte, r_word[63:8]} : {r_word[55:0], i_byte};
      r_cnt  <= r_cnt + 3'd1;
    end
  end

  assign o_word = r_word;
  assign o_last = (r_cnt == 3'(WORD_BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/reg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : reg_loader
//  Description : Loads COUNT 64-bit words from a byte stream into a register
//                file via its side-write port, starting at BASE_ADDR and
//                wrapping modulo 32.
//  Optional    : REG_LOADER_READBACK_EN - after each write, one VERIFY cycle
//                compares dff against swdata; a mismatch sets err (sticky).
//  Ports       : clk, rst_n            clock / async active-low reset
//                start, abort          command / cancel
//                base_addr, count      first register / number of words
//                in_byte, in_valid,    byte stream with handshake
//                in_ready
//                swaddr, swdata, swena register-file side write
//                dff                   register-file readback at swaddr
//                busy, done, err       status (all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_loader
  import reg_loader_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] swaddr,
  output logic [63:0]       swdata,
  output logic              swena,
  input  logic [63:0]       dff,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  state_t            w_next;
  logic              r_in_ready, r_swena, r_busy, r_done, r_err;
  logic              w_in_ready_nxt, w_swena_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_left;
  logic [63:0]       w_word;
  logic              w_pk_last;

  logic w_busy_st, w_start, w_legal, w_abort, w_accept, w_last_byte;
  logic w_word_end, w_last_word;

  assign w_busy_st   = (r_state == ST_COLLECT) || (r_state == ST_WRITE) ||
                       (r_state == ST_VERIFY);
  assign w_start     = (r_state == ST_IDLE) && start;
  assign w_legal     = count_legal(count);
  assign w_abort     = abort && w_busy_st;
  // A byte arriving together with abort is discarded.
  assign w_accept    = (r_state == ST_COLLECT) && in_valid && !abort;
  assign w_last_byte = w_accept && w_pk_last;
  assign w_last_word = (r_left == CNT_W'(1));

`ifdef REG_LOADER_READBACK_EN
  assign w_word_end  = (r_state == ST_VERIFY) && !abort;
`else
  assign w_word_end  = (r_state == ST_WRITE) && !abort;
  logic w_unused_dff;
  assign w_unused_dff = ^dff;
`endif

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_swena    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= w_in_ready_nxt;
      r_swena    <= w_swena_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = w_legal ? ST_COLLECT : ST_DONE;
      ST_COLLECT: begin
        if (abort)            w_next = ST_IDLE;
        else if (w_last_byte) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (abort) w_next = ST_IDLE;
`ifdef REG_LOADER_READBACK_EN
        else       w_next = ST_VERIFY;
`else
        else       w_next = w_last_word ? ST_DONE : ST_COLLECT;
`endif
      end
`ifdef REG_LOADER_READBACK_EN
      ST_VERIFY: begin
        if (abort) w_next = ST_IDLE;
        else       w_next = w_last_word ? ST_DONE : ST_COLLECT;
      end
`endif
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Output decode: outputs are flopped, so decode the state being entered.
  always_comb begin
    w_in_ready_nxt = (w_next == ST_COLLECT);
    w_swena_nxt    = (w_next == ST_WRITE);
    w_busy_nxt     = (w_next == ST_COLLECT) || (w_next == ST_WRITE) ||
                     (w_next == ST_VERIFY);
    w_done_nxt     = (w_next == ST_DONE);
    w_err_nxt      = r_err;
    if (w_start) w_err_nxt = (count > MAX_COUNT);
`ifdef REG_LOADER_READBACK_EN
    if ((r_state == ST_VERIFY) && !abort && (dff != w_word)) w_err_nxt = 1'b1;
`endif
  end

  // Address / remaining-word bookkeeping; address wraps naturally at 32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_left <= '0;
    end else if (w_start && w_legal) begin
      r_addr <= base_addr;
      r_left <= count;
    end else if (w_word_end) begin
      r_addr <= r_addr + ADDR_W'(1);
      r_left <= r_left - CNT_W'(1);
    end
  end

  byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start || w_abort),
    .i_shift     (w_accept),
    .i_lsb_first (LSB_FIRST != 0),
    .i_byte      (in_byte),
    .o_word      (w_word),
    .o_last      (w_pk_last)
  );

  assign in_ready = r_in_ready;
  assign swaddr   = r_addr;
  assign swdata   = w_word;
  assign swena    = r_swena;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_loader
//  Description : Directed self-checking bench for reg_loader. Two instances
//                (LSB_FIRST=1 and LSB_FIRST=0) share one stimulus stream,
//                each with its own register-file model.
//  Optional    : REG_LOADER_READBACK_EN changes the expected err in the
//                readback scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, in_valid;
  logic [4:0]  base_addr;
  logic [5:0]  count;
  logic [7:0]  in_byte;

  logic        rdy_l, ena_l, busy_l, done_l, err_l;
  logic [4:0]  addr_l;
  logic [63:0] data_l, dff_l;
  logic        rdy_m, ena_m, busy_m, done_m, err_m;
  logic [4:0]  addr_m;
  logic [63:0] data_m, dff_m;

  logic [63:0] rf_l [32] = '{default: '0};
  logic [63:0] rf_m [32] = '{default: '0};
  logic        drop7 = 1'b0;

  logic [68:0] ql[$];
  logic [68:0] qm[$];
  int          done_cnt  = 0;
  logic        done_busy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_loader #(.LSB_FIRST(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(rdy_l), .swaddr(addr_l),
    .swdata(data_l), .swena(ena_l), .dff(dff_l), .busy(busy_l),
    .done(done_l), .err(err_l)
  );

  reg_loader #(.LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(rdy_m), .swaddr(addr_m),
    .swdata(data_m), .swena(ena_m), .dff(dff_m), .busy(busy_m),
    .done(done_m), .err(err_m)
  );

  // Register-file models; drop7 loses every write to address 7.
  always @(posedge clk) begin
    if (ena_l && !(drop7 && addr_l == 5'd7)) rf_l[addr_l] <= data_l;
    if (ena_m && !(drop7 && addr_m == 5'd7)) rf_m[addr_m] <= data_m;
  end
  assign dff_l = rf_l[addr_l];
  assign dff_m = rf_m[addr_m];

  // Write / completion monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ena_l) ql.push_back({addr_l, data_l});
      if (ena_m) qm.push_back({addr_m, data_m});
      if (done_l) begin
        done_cnt  = done_cnt + 1;
        done_busy = busy_l;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [68:0] ent_l(input int i);
    if (i < ql.size()) return ql[i];
    return '0;
  endfunction

  function automatic logic [68:0] ent_m(input int i);
    if (i < qm.size()) return qm[i];
    return '0;
  endfunction

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    ql.delete();
    qm.delete();
    done_cnt  = 0;
    done_busy = 1'b0;
  endtask

  task automatic start_load(input logic [4:0] b, input logic [5:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    cyc(1);
    start     = 1'b0;
  endtask

  // Feeds n bytes b0, b0+step, ...; a byte advances only when accepted.
  task automatic feed(input logic [7:0] b0, input logic [7:0] step, input int n,
                      input bit gaps);
    int   idx   = 0;
    int   guard = 0;
    logic acc;
    while (idx < n && guard < 2000) begin
      in_byte  = b0 + step * 8'(idx);
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      acc      = in_valid && rdy_l;
      cyc(1);
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check("feed_bytes_accepted", 64'(idx), 64'(n));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    base_addr = '0; count = '0; in_byte = '0;
    cyc(3);
    check("rst_busy",   64'(busy_l),  64'd0);
    check("rst_ready",  64'(rdy_l),   64'd0);
    check("rst_swena",  64'(ena_l),   64'd0);
    check("rst_swaddr", 64'(addr_l),  64'd0);
    check("rst_swdata", data_l,       64'd0);
    check("rst_err",    64'(err_l),   64'd0);
    rst_n = 1'b1;
    cyc(2);

    // Two words at base 4, bytes 0x01..0x10, valid held high.
    clear_logs();
    start_load(5'd4, 6'd2);
    check("a_busy_after_start", 64'(busy_l), 64'd1);
    feed(8'h01, 8'h01, 16, 1'b0);
    cyc(5);
    check("a_nwrites", 64'(ql.size()), 64'd2);
    check("a_addr0",   64'(ent_l(0)[68:64]), 64'd4);
    check("a_data0",   ent_l(0)[63:0], 64'h0807060504030201);
    check("a_addr1",   64'(ent_l(1)[68:64]), 64'd5);
    check("a_data1",   ent_l(1)[63:0], 64'h100F0E0D0C0B0A09);
    check("a_msb0",    ent_m(0)[63:0], 64'h0102030405060708);
    check("a_msb1",    ent_m(1)[63:0], 64'h090A0B0C0D0E0F10);
    check("a_done",    64'(done_cnt), 64'd1);
    check("a_err",     64'(err_l), 64'd0);

    // Address wrap 31 -> 0; busy low in done cycle.
    clear_logs();
    start_load(5'd31, 6'd2);
    feed(8'h80, 8'h01, 16, 1'b0);
    cyc(5);
    check("b_addr0",     64'(ent_l(0)[68:64]), 64'd31);
    check("b_addr1",     64'(ent_l(1)[68:64]), 64'd0);
    check("b_data1",     ent_l(1)[63:0], 64'h8F8E8D8C8B8A8988);
    check("b_done",      64'(done_cnt), 64'd1);
    check("b_busy_done", 64'(done_busy), 64'd0);

    // count = 0: done only, no writes, no error.
    clear_logs();
    start_load(5'd10, 6'd0);
    cyc(3);
    check("c0_done",    64'(done_cnt), 64'd1);
    check("c0_nwrites", 64'(ql.size()), 64'd0);
    check("c0_err",     64'(err_l), 64'd0);

    // count = 40: done with err, no writes.
    clear_logs();
    start_load(5'd10, 6'd40);
    cyc(3);
    check("c40_done",    64'(done_cnt), 64'd1);
    check("c40_nwrites", 64'(ql.size()), 64'd0);
    check("c40_err",     64'(err_l), 64'd1);

    // Abort after 5th byte of 2nd word; the new start clears err.
    clear_logs();
    start_load(5'd2, 6'd2);
    check("ab_err_cleared", 64'(err_l), 64'd0);
    feed(8'h20, 8'h01, 13, 1'b0);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("ab_busy", 64'(busy_l), 64'd0);
    cyc(4);
    check("ab_nwrites", 64'(ql.size()), 64'd1);
    check("ab_done",    64'(done_cnt), 64'd0);

    // Abort in the same cycle as the 8th byte wins.
    clear_logs();
    start_load(5'd9, 6'd1);
    feed(8'h30, 8'h01, 7, 1'b0);
    in_byte = 8'h37; in_valid = 1'b1; abort = 1'b1;
    cyc(1);
    in_valid = 1'b0; abort = 1'b0;
    cyc(4);
    check("ab8_nwrites", 64'(ql.size()), 64'd0);
    check("ab8_done",    64'(done_cnt), 64'd0);
    // Next load starts from a clean word.
    start_load(5'd9, 6'd1);
    feed(8'h40, 8'h01, 8, 1'b0);
    cyc(5);
    check("ab8_reload_addr", 64'(ent_l(0)[68:64]), 64'd9);
    check("ab8_reload_data", ent_l(0)[63:0], 64'h4746454443424140);

    // Reset mid-word clears outputs without waiting for a clock edge.
    start_load(5'd3, 6'd1);
    feed(8'h55, 8'h01, 3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_busy",   64'(busy_l), 64'd0);
    check("mrst_ready",  64'(rdy_l),  64'd0);
    check("mrst_swaddr", 64'(addr_l), 64'd0);
    check("mrst_swdata", data_l,      64'd0);
    check("mrst_done",   64'(done_l), 64'd0);
    check("mrst_swena",  64'(ena_l),  64'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // Register file drops the write to address 7.
    clear_logs();
    drop7 = 1'b1;
    start_load(5'd6, 6'd3);
    feed(8'h61, 8'h03, 24, 1'b0);
    cyc(6);
    drop7 = 1'b0;
    check("rb_nwrites", 64'(ql.size()), 64'd3);
    check("rb_addr2",   64'(ent_l(2)[68:64]), 64'd8);
    check("rb_done",    64'(done_cnt), 64'd1);
`ifdef REG_LOADER_READBACK_EN
    check("rb_err", 64'(err_l), 64'd1);
`else
    check("rb_err", 64'(err_l), 64'd0);
`endif

    // Random valid gaps, bytes 0xAA, 0xBB, ... (step 0x11).
    clear_logs();
    start_load(5'd12, 6'd2);
    feed(8'hAA, 8'h11, 16, 1'b1);
    cyc(6);
    check("g_nwrites", 64'(qm.size()), 64'd2);
    check("g_msb0",    ent_m(0)[63:0], 64'hAABBCCDDEEFF1021);
    check("g_msb1",    ent_m(1)[63:0], 64'h32435465768798A9);
    check("g_lsb0",    ent_l(0)[63:0], 64'h2110FFEEDDCCBBAA);
    check("g_lsb1",    ent_l(1)[63:0], 64'hA998877665544332);
    check("g_rf13",    rf_m[13], 64'h32435465768798A9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
